fetch_unit: RTL and testbench

- Parametrised instruction fetch front end for the next-generation simple RISC machine.
- Owns the fetch PC and issues memory reads. Buffers returned instruction words in a DEPTH-entry prefetch queue.
- Presents words to the decoder/controller through a valid/ready handshake.
- Supports branch redirect with queue flush and discard of in-flight responses. Yields the memory port to the datapath on request.

---
 rtl/fetch_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end; owns the fetch PC, issues in-order reads, buffers returned words in a prefetch queue.
// Latency: a returned word reaches the queue head the cycle after mem_rvalid (two cycles after issue with single-cycle memory).
// Backpressure: issue stalls on mem_busy, on redirect, and while queued + in-flight words would exceed DEPTH; head waits on instr_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_cmd/mem_addr          : read request (01 = read, 00 = idle), address is the fetch PC
//   mem_busy                  : datapath owns memory this cycle, no read issues
//   mem_rvalid/read_data      : in-order response to the oldest outstanding read
//   redirect/redirect_pc      : taken branch, flush queue and refetch from redirect_pc
//   instr_valid/instr_ready   : head-of-queue handshake, instr/instr_pc carry word and its address
//
// Optional build macro FETCH_STATS_EN adds fetch_count (consumed words) and flush_count
// (redirect cycles), both 16-bit, reset to zero and saturating at all-ones.

module fetch_unit #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_busy,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] read_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       flush_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0]        CMD_NONE = 2'b00;
    localparam logic [1:0]        CMD_READ = 2'b01;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [CNT_W:0]    OCC_MAX  = (CNT_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q,     discard_d;
    logic [PTR_W-1:0]  q_wr_ptr_q,    q_wr_ptr_d;
    logic [PTR_W-1:0]  q_rd_ptr_q,    q_rd_ptr_d;
    logic [PTR_W-1:0]  tag_wr_ptr_q,  tag_wr_ptr_d;
    logic [PTR_W-1:0]  tag_rd_ptr_q,  tag_rd_ptr_d;
    logic [DATA_W-1:0] instr_q,       instr_d;
    logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;

    // Prefetch queue storage and the address tags of in-flight reads.
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] tag_mem_q  [DEPTH];

    // ------------------------------------------------------------------
    // Per-cycle events
    // ------------------------------------------------------------------
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              rsp;
    logic              rsp_keep;
    logic              pop;
    logic [ADDR_W-1:0] rsp_tag;
    logic [CNT_W-1:0]  count_left;

    // Queued words plus reads in flight: every in-flight read already owns a queue slot,
    // so a response can never find the queue full.
    assign occupancy = {1'b0, count_q} + {1'b0, outstanding_q};

    assign issue = reset && !mem_busy && !redirect && (occupancy < OCC_MAX);

    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign rsp = mem_rvalid && (outstanding_q != '0);

    // Responses belonging to reads issued before a redirect are dropped via discard.
    assign rsp_keep = rsp && !redirect && (discard_q == '0);

    assign pop = (count_q != '0) && instr_ready && !redirect;

    assign rsp_tag = tag_mem_q[tag_rd_ptr_q];

    assign mem_cmd     = issue ? CMD_READ : CMD_NONE;
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        q_wr_ptr_d    = q_wr_ptr_q;
        q_rd_ptr_d    = q_rd_ptr_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        count_left    = count_q - CNT_W'(pop);

        // The tag FIFO mirrors every read on the bus, discarded or not, so its
        // depth always equals outstanding.
        if (issue) begin
            fetch_pc_d   = fetch_pc_q + PC_ONE;
            tag_wr_ptr_d = tag_wr_ptr_q + PTR_ONE;
        end
        if (rsp) begin
            tag_rd_ptr_d = tag_rd_ptr_q + PTR_ONE;
        end

        unique case ({issue, rsp})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            q_wr_ptr_d = '0;
            q_rd_ptr_d = '0;
            // Every read still in flight after this cycle predates the redirect,
            // including any left over from an earlier undrained redirect.
            discard_d  = outstanding_q - CNT_W'(rsp);
        end else begin
            if (rsp && (discard_q != '0)) begin
                discard_d = discard_q - CNT_ONE;
            end
            if (rsp_keep) begin
                q_wr_ptr_d = q_wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                q_rd_ptr_d = q_rd_ptr_q + PTR_ONE;
            end
            count_d = count_left + CNT_W'(rsp_keep);

            // Head registers: reload from the new head slot, or take the incoming
            // word when it lands in an otherwise empty queue. When the queue goes
            // empty they keep the last presented word.
            if (count_left != '0) begin
                instr_d    = data_mem_q[q_rd_ptr_d];
                instr_pc_d = pc_mem_q[q_rd_ptr_d];
            end else if (rsp_keep) begin
                instr_d    = read_data;
                instr_pc_d = rsp_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            q_wr_ptr_q    <= '0;
            q_rd_ptr_q    <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            q_wr_ptr_q    <= q_wr_ptr_d;
            q_rd_ptr_q    <= q_rd_ptr_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Storage arrays need no reset: occupancy counters gate every read of them.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem_q[tag_wr_ptr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            data_mem_q[q_wr_ptr_q] <= read_data;
            pc_mem_q[q_wr_ptr_q]   <= rsp_tag;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (pop && (fetch_count_q != '1)) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
            if (redirect && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic        mem_busy;
    logic        mem_rvalid;
    logic [15:0] read_data;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [8:0]  instr_pc;

    // Narrow-PC instance (ADDR_W=4, RESET_PC=14) for wrap-around.
    logic [1:0]  s_mem_cmd;
    logic [3:0]  s_mem_addr;
    logic        s_mem_rvalid;
    logic [15:0] s_read_data;
    logic        s_instr_valid;
    logic [15:0] s_instr;
    logic [3:0]  s_instr_pc;

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count, flush_count, s_fetch_count, s_flush_count;
`endif

    int         total = 0;
    int         bad   = 0;
    bit         hold  = 0;
    logic [8:0] pq[$];

    fetch_unit dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_busy(mem_busy), .mem_rvalid(mem_rvalid), .read_data(read_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    fetch_unit #(.ADDR_W(4), .DATA_W(16), .DEPTH(4), .RESET_PC(4'd14)) dut_small (
        .clk(clk), .reset(reset), .mem_cmd(s_mem_cmd), .mem_addr(s_mem_addr),
        .mem_busy(1'b0), .mem_rvalid(s_mem_rvalid), .read_data(s_read_data),
        .redirect(1'b0), .redirect_pc(4'd0), .instr_valid(s_instr_valid),
        .instr_ready(1'b1), .instr(s_instr), .instr_pc(s_instr_pc)
`ifdef FETCH_STATS_EN
        , .fetch_count(s_fetch_count), .flush_count(s_flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] memword(input logic [8:0] a);
        if (a == 9'd0) return 16'h1234;
        return 16'hC000 | {7'd0, a};
    endfunction

    // One clock: sample requests mid-cycle, then drive next-cycle responses.
    // Main memory answers the oldest queued read one per cycle unless held.
    task automatic tick();
        logic       iss, s_iss;
        logic [8:0] a;
        logic [3:0] sa;
        @(negedge clk);
        iss   = (mem_cmd == 2'b01);
        a     = mem_addr;
        s_iss = (s_mem_cmd == 2'b01);
        sa    = s_mem_addr;
        @(posedge clk);
        #1;
        if (iss) pq.push_back(a);
        mem_rvalid = 1'b0;
        if (!hold && pq.size() > 0) begin
            mem_rvalid = 1'b1;
            read_data  = memword(pq.pop_front());
        end
        s_mem_rvalid = s_iss;
        s_read_data  = 16'hB000 | {12'd0, sa};
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; mem_busy = 1'b0; redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; hold = 1'b0; mem_rvalid = 1'b0; s_mem_rvalid = 1'b0;
        pq.delete();
        tick();
        tick();
        pq.delete(); mem_rvalid = 1'b0; s_mem_rvalid = 1'b0;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_busy = 1'b0; redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b1; hold = 1'b0; mem_rvalid = 1'b0; read_data = '0;
        s_mem_rvalid = 1'b0; s_read_data = '0;
        tick();
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (instr !== 16'h0) begin bad++; $display("FAIL reset_instr: got %h want 0000", instr); end
        total++; if (instr_pc !== 9'h0) begin bad++; $display("FAIL reset_pc: got %h want 000", instr_pc); end
        total++; if (mem_cmd !== 2'b00) begin bad++; $display("FAIL reset_cmd: got %b want 00", mem_cmd); end
        total++; if (mem_addr !== 9'h0) begin bad++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
        total++; if (s_mem_addr !== 4'd14) begin bad++; $display("FAIL reset_small_addr: got %0d want 14", s_mem_addr); end
        pq.delete();
        reset = 1'b1;
        #1;
        total++; if (mem_cmd !== 2'b01) begin bad++; $display("FAIL reset_release_cmd: got %b want 01", mem_cmd); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (mem_cmd !== 2'b01 || mem_addr !== 9'(k)) begin
                bad++; $display("FAIL stream_issue[%0d]: got cmd=%b addr=%h want cmd=01 addr=%h", k, mem_cmd, mem_addr, 9'(k));
            end
            if (k >= 2) begin
                total++;
                if (instr_valid !== 1'b1 || instr_pc !== 9'(k - 2) || instr !== memword(9'(k - 2))) begin
                    bad++; $display("FAIL stream_head[%0d]: got v=%b pc=%h w=%h want v=1 pc=%h w=%h",
                                    k, instr_valid, instr_pc, instr, 9'(k - 2), memword(9'(k - 2)));
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (k < 4) begin
                if (mem_cmd !== 2'b01 || mem_addr !== 9'(k)) begin
                    bad++; $display("FAIL full_issue[%0d]: got cmd=%b addr=%h want cmd=01 addr=%h", k, mem_cmd, mem_addr, 9'(k));
                end
            end else if (mem_cmd !== 2'b00) begin
                bad++; $display("FAIL full_stall[%0d]: got cmd=%b want 00", k, mem_cmd);
            end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        for (int k = 8; k < 14; k++) begin
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== 9'(k - 8) || instr !== memword(9'(k - 8))) begin
                bad++; $display("FAIL full_drain[%0d]: got v=%b pc=%h w=%h want v=1 pc=%h", k, instr_valid, instr_pc, instr, 9'(k - 8));
            end
            if (k == 8) begin
                total++; if (mem_cmd !== 2'b00) begin bad++; $display("FAIL full_first_pop_cmd: got %b want 00", mem_cmd); end
            end
            if (k == 9) begin
                total++;
                if (mem_cmd !== 2'b01 || mem_addr !== 9'd4) begin
                    bad++; $display("FAIL full_resume: got cmd=%b addr=%h want cmd=01 addr=004", mem_cmd, mem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        instr_ready = 1'b0;
        tick();               // cycle 1
        tick();               // cycle 2
        hold = 1'b1;
        tick();               // cycle 3
        tick();               // cycle 4: 2 queued, 2 outstanding
        total++; if (instr_valid !== 1'b1 || instr_pc !== 9'd0) begin bad++; $display("FAIL redir_pre_head: got v=%b pc=%h want v=1 pc=000", instr_valid, instr_pc); end
        total++; if (mem_cmd !== 2'b00) begin bad++; $display("FAIL redir_pre_full: got %b want 00", mem_cmd); end
        redirect = 1'b1; redirect_pc = 9'h040;
        tick();               // cycle 5
        redirect = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", instr_valid); end
        total++;
        if (mem_cmd !== 2'b01 || mem_addr !== 9'h040) begin
            bad++; $display("FAIL redir_refetch: got cmd=%b addr=%h want cmd=01 addr=040", mem_cmd, mem_addr);
        end
        hold = 1'b0;
        tick();               // cycle 6: stale responses begin
        n = 0;
        while (instr_valid !== 1'b1 && n < 10) begin tick(); n++; end
        total++; if (n !== 3) begin bad++; $display("FAIL redir_delay: got %0d cycles want 3", n); end
        total++;
        if (instr_pc !== 9'h040 || instr !== memword(9'h040)) begin
            bad++; $display("FAIL redir_first_word: got pc=%h w=%h want pc=040 w=%h", instr_pc, instr, memword(9'h040));
        end
    endtask

    task automatic test_busy();
        logic [8:0] exp_addr, exp_pc;
        do_reset();
        instr_ready = 1'b1;
        exp_addr = '0; exp_pc = '0;
        for (int k = 0; k < 12; k++) begin
            mem_busy = (k >= 2 && k <= 4);
            #1;
            total++;
            if (k >= 2 && k <= 4) begin
                if (mem_cmd !== 2'b00) begin bad++; $display("FAIL busy_stall[%0d]: got %b want 00", k, mem_cmd); end
            end else begin
                if (mem_cmd !== 2'b01 || mem_addr !== exp_addr) begin
                    bad++; $display("FAIL busy_issue[%0d]: got cmd=%b addr=%h want cmd=01 addr=%h", k, mem_cmd, mem_addr, exp_addr);
                end
                exp_addr++;
            end
            if (instr_valid === 1'b1) begin
                total++;
                if (instr_pc !== exp_pc || instr !== memword(exp_pc)) begin
                    bad++; $display("FAIL busy_order[%0d]: got pc=%h w=%h want pc=%h", k, instr_pc, instr, exp_pc);
                end
                exp_pc++;
            end
            tick();
        end
        mem_busy = 1'b0;
        total++; if (exp_pc !== 9'd7) begin bad++; $display("FAIL busy_delivered: got %0d want 7", exp_pc); end
    endtask

    task automatic test_spurious();
        do_reset();
        mem_busy = 1'b1;
        mem_rvalid = 1'b1;
        read_data = 16'hDEAD;
        #1;
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL spurious_ignored: got %b want 0", instr_valid); end
        mem_busy = 1'b0;
        #1;
        total++;
        if (mem_cmd !== 2'b01 || mem_addr !== 9'd0) begin
            bad++; $display("FAIL spurious_issue: got cmd=%b addr=%h want cmd=01 addr=000", mem_cmd, mem_addr);
        end
        tick();
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 9'd0 || instr !== 16'h1234) begin
            bad++; $display("FAIL spurious_word: got v=%b pc=%h w=%h want v=1 pc=000 w=1234", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_redirect_same_cycle();
        int n;
        do_reset();
        instr_ready = 1'b0;
        tick();               // cycle 1
        hold = 1'b1;
        tick();               // cycle 2
        hold = 1'b0;
        tick();               // cycle 3: response for addr 1 arrives, addr 2 in flight
        redirect = 1'b1; redirect_pc = 9'h080; instr_ready = 1'b1;
        #1;
        total++; if (instr_valid !== 1'b1 || mem_rvalid !== 1'b1) begin bad++; $display("FAIL same_setup: got v=%b rv=%b want 1 1", instr_valid, mem_rvalid); end
        total++; if (mem_cmd !== 2'b00) begin bad++; $display("FAIL same_no_issue: got %b want 00", mem_cmd); end
        tick();               // cycle 4: stale response for addr 2
        redirect = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL same_flush: got %b want 0", instr_valid); end
        total++;
        if (mem_cmd !== 2'b01 || mem_addr !== 9'h080) begin
            bad++; $display("FAIL same_refetch: got cmd=%b addr=%h want cmd=01 addr=080", mem_cmd, mem_addr);
        end
`ifdef FETCH_STATS_EN
        total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL same_fetch_count: got %0d want 0", fetch_count); end
        total++; if (flush_count !== 16'd1) begin bad++; $display("FAIL same_flush_count: got %0d want 1", flush_count); end
`endif
        tick();               // cycle 5
        n = 0;
        while (instr_valid !== 1'b1 && n < 10) begin tick(); n++; end
        total++; if (n !== 1) begin bad++; $display("FAIL same_delay: got %0d cycles want 1", n); end
        total++;
        if (instr_pc !== 9'h080 || instr !== memword(9'h080)) begin
            bad++; $display("FAIL same_first_word: got pc=%h w=%h want pc=080 w=%h", instr_pc, instr, memword(9'h080));
        end
`ifdef FETCH_STATS_EN
        tick();
        total++; if (fetch_count !== 16'd1) begin bad++; $display("FAIL same_fetch_after: got %0d want 1", fetch_count); end
`endif
    endtask

    task automatic test_wrap();
        logic [3:0] seq [6];
        seq = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            total++;
            if (s_mem_cmd !== 2'b01 || s_mem_addr !== seq[k]) begin
                bad++; $display("FAIL wrap_issue[%0d]: got cmd=%b addr=%0d want cmd=01 addr=%0d", k, s_mem_cmd, s_mem_addr, seq[k]);
            end
            if (k >= 2) begin
                total++;
                if (s_instr_valid !== 1'b1 || s_instr_pc !== seq[k - 2] || s_instr !== (16'hB000 | {12'd0, seq[k - 2]})) begin
                    bad++; $display("FAIL wrap_head[%0d]: got v=%b pc=%0d w=%h want v=1 pc=%0d", k, s_instr_valid, s_instr_pc, s_instr, seq[k - 2]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_busy();
        test_spurious();
        test_redirect_same_cycle();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
